// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined bitwise NOT/AND/OR/XOR unit with valid/ready flow control
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             upstream handshake for operands in_a, in_b, in_op
//   in_op                         00 ~a, 01 a&b, 10 a|b, 11 a^b
//   out_valid/out_ready           downstream handshake for out_data and out_zero
//   out_zero                      out_data is all zeros
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);
    logic [STAGES-1:0] v_q, v_d, z_q, z_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [STAGES:0]   en;
    logic [WIDTH-1:0]  res;
    always_comb begin
        res = in_op == 2'b00 ? ~in_a :
              in_op == 2'b01 ? in_a & in_b :
              in_op == 2'b10 ? in_a | in_b : in_a ^ in_b;
    end
    // a stage may advance if it is empty or the stage after it advances;
    // evaluated from the output back so the ready chain settles in one pass
    always_comb begin
        en[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            en[k] = !v_q[k] | en[k+1];
    end
    assign in_ready = en[0];
    always_comb begin
        v_d = v_q;
        z_d = z_q;
        d_d = d_q;
        if (en[0]) begin
            v_d[0] = in_valid;
            d_d[0] = res;
            z_d[0] = res == '0;
        end
        for (int k = 1; k < STAGES; k++)
            if (en[k]) begin
                v_d[k] = v_q[k-1];
                d_d[k] = d_q[k-1];
                z_d[k] = z_q[k-1];
            end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            z_q <= '0;
            d_q <= '{default: '0};
        end else begin
            v_q <= v_d;
            z_q <= z_d;
            d_q <= d_d;
        end
    end
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign out_zero  = z_q[STAGES-1];
endmodule
